// File: rtl/outport_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : outport_fifo
//  Purpose  : Per-port output channel of the router, downstream of the
//             crossbar. Buffers granted flits in a small circular FIFO and
//             drives them onto the inter-router link under valid/ready flow
//             control. Reports rdy/lck status back to the crossbar arbiter;
//             lck holds the port for a packet from its HEAD to its TAIL.
//  Ports    :
//    clk        router clock
//    rst_n      asynchronous active-low reset
//    in_valid   flit from crossbar valid this cycle
//    in_type    flit type: 00 BODY, 01 HEAD, 10 TAIL, 11 HEADTAIL
//    in_flit    flit payload from crossbar
//    rdy_o      FIFO can accept a flit this cycle (count != DEPTH)
//    lck_o      port owned by a packet in progress
//    out_valid  flit at FIFO head valid toward downstream link
//    out_type   type of flit at FIFO head
//    out_flit   payload of flit at FIFO head
//    out_ready  downstream input channel can accept
//    count_o    current occupancy
//    err_o      sticky protocol-error flag
//  Revision : 1.0  initial release
// ============================================================================
module outport_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        in_type,
    input  logic [DATA_W-1:0] in_flit,
    output logic              rdy_o,
    output logic              lck_o,
    output logic              out_valid,
    output logic [1:0]        out_type,
    output logic [DATA_W-1:0] out_flit,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count_o,
    output logic              err_o
);

    localparam int             PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] TYPE_BODY     = 2'b00;
    localparam logic [1:0] TYPE_HEAD     = 2'b01;
    localparam logic [1:0] TYPE_TAIL     = 2'b10;
    localparam logic [1:0] TYPE_HEADTAIL = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_flit_q [DEPTH];
    logic [1:0]        mem_type_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    lock_state_t       state_q,  state_d;
    logic              err_q,    err_d;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              type_err;

    // ------------------------------------------------------------------
    // Status derived from registers only, so there is no combinational
    // path from the crossbar side to the link side. A pop while full does
    // not open the FIFO for a push in the same cycle.
    // ------------------------------------------------------------------
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);

    assign rdy_o     = !full;
    assign out_valid = !empty;
    assign out_flit  = mem_flit_q[rd_ptr_q];
    assign out_type  = mem_type_q[rd_ptr_q];
    assign count_o   = count_q;
    assign lck_o     = (state_q == ST_LOCKED);
    assign err_o     = err_q;

    assign push = in_valid & rdy_o;
    assign pop  = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Storage: not reset; the head is only meaningful while out_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_flit_q[wr_ptr_q] <= in_flit;
            mem_type_q[wr_ptr_q] <= in_type;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy. DEPTH is a power of two, so natural
    // overflow of the pointer width gives the DEPTH-1 -> 0 wrap.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Packet lock FSM, advanced only by accepted flits. Out-of-order
    // types are flagged but the flit is still stored and forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        type_err = 1'b0;

        if (push) begin
            case (state_q)
                ST_IDLE: begin
                    case (in_type)
                        TYPE_HEAD:     state_d  = ST_LOCKED;
                        TYPE_HEADTAIL: state_d  = ST_IDLE;
                        default:       type_err = 1'b1;
                    endcase
                end
                ST_LOCKED: begin
                    case (in_type)
                        TYPE_BODY:     state_d  = ST_LOCKED;
                        TYPE_TAIL:     state_d  = ST_IDLE;
                        default:       type_err = 1'b1;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sticky error: a flit offered while full is dropped, or a type
    // sequence violation was accepted.
    always_comb begin
        err_d = err_q;
        if ((in_valid && full) || type_err) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            err_q    <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_outport_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_outport_fifo
//  Purpose  : Self-checking bench for outport_fifo. A queue-based model of
//             the output channel predicts every output each cycle; directed
//             sequences add literal expectations for key scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_outport_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [1:0]        in_type;
    logic [DATA_W-1:0] in_flit;
    logic              rdy_o;
    logic              lck_o;
    logic              out_valid;
    logic [1:0]        out_type;
    logic [DATA_W-1:0] out_flit;
    logic              out_ready;
    logic [CNT_W-1:0]  count_o;
    logic              err_o;

    outport_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_type   (in_type),
        .in_flit   (in_flit),
        .rdy_o     (rdy_o),
        .lck_o     (lck_o),
        .out_valid (out_valid),
        .out_type  (out_type),
        .out_flit  (out_flit),
        .out_ready (out_ready),
        .count_o   (count_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a queue of {type, flit} plus lock and error bits.
    // ------------------------------------------------------------------
    logic [DATA_W+1:0] m_q [$];
    bit                m_lock;
    bit                m_err;

    int n_vec;
    int n_miss;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_lock = 1'b0;
        m_err  = 1'b0;
    endtask

    // Applies one clock edge worth of behaviour using the current inputs.
    task automatic model_edge();
        bit do_push;
        bit do_pop;
        do_push = in_valid && (m_q.size() < DEPTH);
        do_pop  = out_ready && (m_q.size() > 0);
        if (in_valid && !do_push) m_err = 1'b1;
        if (do_push) begin
            if (!m_lock) begin
                if (in_type == T_HEAD)                          m_lock = 1'b1;
                else if (in_type == T_BODY || in_type == T_TAIL) m_err  = 1'b1;
            end else begin
                if (in_type == T_TAIL)                          m_lock = 1'b0;
                else if (in_type == T_HEAD || in_type == T_HT)  m_err  = 1'b1;
            end
        end
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back({in_type, in_flit});
    endtask

    task automatic compare_all();
        chk("count",     64'(count_o),   64'(m_q.size()));
        chk("rdy",       64'(rdy_o),     64'(m_q.size() != DEPTH));
        chk("lck",       64'(lck_o),     64'(m_lock));
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("err",       64'(err_o),     64'(m_err));
        if (m_q.size() != 0) begin
            chk("out_flit", 64'(out_flit), 64'(m_q[0][DATA_W-1:0]));
            chk("out_type", 64'(out_type), 64'(m_q[0][DATA_W+1:DATA_W]));
        end
    endtask

    // Called at a negedge: drive inputs, take the edge, compare at next negedge.
    task automatic step(input bit v, input logic [1:0] t, input logic [DATA_W-1:0] f, input bit r);
        in_valid  = v;
        in_type   = t;
        in_flit   = f;
        out_ready = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        chk("rst_count", 64'(count_o),   64'd0);
        chk("rst_rdy",   64'(rdy_o),     64'd1);
        chk("rst_lck",   64'(lck_o),     64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_err",   64'(err_o),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_type   = T_BODY;
        in_flit   = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset mid-stream with three buffered flits and an open packet.
        step(1'b1, T_HEAD, 32'h1, 1'b0);
        step(1'b1, T_BODY, 32'h2, 1'b0);
        step(1'b1, T_BODY, 32'h3, 1'b0);
        chk("pre_rst_count", 64'(count_o), 64'd3);
        chk("pre_rst_lck",   64'(lck_o),   64'd1);
        do_reset();

        // Single-flit packet.
        step(1'b1, T_HT, 32'hA5, 1'b1);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_flit",  64'(out_flit),  64'hA5);
        chk("single_lck",   64'(lck_o),     64'd0);
        step(1'b0, T_BODY, 32'h0, 1'b1);
        chk("single_drain", 64'(out_valid), 64'd0);

        // Fill under backpressure, overflow attempt, then drain in order.
        step(1'b1, T_HEAD, 32'h10, 1'b0);
        step(1'b1, T_BODY, 32'h11, 1'b0);
        step(1'b1, T_BODY, 32'h12, 1'b0);
        step(1'b1, T_BODY, 32'h13, 1'b0);
        chk("full_count", 64'(count_o), 64'd4);
        chk("full_rdy",   64'(rdy_o),   64'd0);
        chk("full_lck",   64'(lck_o),   64'd1);
        step(1'b1, T_TAIL, 32'h14, 1'b0);
        chk("ovf_err",   64'(err_o),   64'd1);
        chk("ovf_count", 64'(count_o), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", 64'(out_flit), 64'(32'h10 + i));
            step(1'b0, T_BODY, 32'h0, 1'b1);
        end
        chk("drain_empty", 64'(count_o), 64'd0);

        // Lock sequence from clean reset.
        do_reset();
        step(1'b1, T_HEAD, 32'h21, 1'b1);
        chk("lock_head", 64'(lck_o), 64'd1);
        step(1'b1, T_BODY, 32'h22, 1'b1);
        chk("lock_body", 64'(lck_o), 64'd1);
        step(1'b1, T_TAIL, 32'h23, 1'b1);
        chk("lock_tail", 64'(lck_o), 64'd0);
        chk("lock_err",  64'(err_o), 64'd0);
        step(1'b0, T_BODY, 32'h0, 1'b1);

        // Streaming push+pop every cycle across pointer wrap.
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, T_HT, DATA_W'(i), 1'b1);
            chk("stream_count", 64'(count_o),  64'd1);
            chk("stream_flit",  64'(out_flit), 64'(i));
        end
        step(1'b0, T_BODY, 32'h0, 1'b1);

        // BODY from IDLE: flagged but delivered.
        do_reset();
        step(1'b1, T_BODY, 32'h11, 1'b0);
        chk("perr_err",  64'(err_o),    64'd1);
        chk("perr_lck",  64'(lck_o),    64'd0);
        chk("perr_flit", 64'(out_flit), 64'h11);
        step(1'b0, T_BODY, 32'h0, 1'b1);

        // Randomised traffic, mostly well-formed packets with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] t;
            int sel;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                sel = $urandom_range(0, 15);
                if (sel == 0) t = 2'($urandom_range(0, 3));
                else if (!m_lock) t = ($urandom_range(0, 1) != 0) ? T_HEAD : T_HT;
                else t = ($urandom_range(0, 2) == 0) ? T_TAIL : T_BODY;
                step($urandom_range(0, 2) != 0, t, $urandom, $urandom_range(0, 2) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
